rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters:
  - requester 0: main pipeline writeback.
  - requester 1: long-latency unit, e.g. multiply/divide.
- Fixed priority to requester 0, with anti-starvation aging for requester 1.
- Registers the winning write onto the register-file write port (rd / writedata / regwrite).
- Optional scoreboard tracks registers with outstanding long-latency writes and stalls issue on hazards.

Parameters:
- MAX_WAIT, 4, consecutive denied cycles after which requester 1 gets priority for one arbitration; legal range 1..15.
- CNT_W, 4, width of the starvation counter; must hold MAX_WAIT.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- wb0_valid  in  1  requester 0 has a write.
- wb0_ready  out  1  requester 0 granted this cycle.
- wb0_rd  in  5  requester 0 destination register.
- wb0_data  in  32  requester 0 write data.
- wb1_valid  in  1  requester 1 has a write.
- wb1_ready  out  1  requester 1 granted this cycle.
- wb1_rd  in  5  requester 1 destination register.
- wb1_data  in  32  requester 1 write data.
- rf_regwrite  out  1  register-file write enable.
- rf_rd  out  5  register-file write address.
- rf_writedata  out  32  register-file write data.
- iss_valid  in  1  decode presenting an instruction.
- iss_rs  in  5  instruction source register rs.
- iss_rt  in  5  instruction source register rt.
- iss_rd  in  5  instruction destination register.
- iss_we  in  1  instruction writes iss_rd.
- iss_long  in  1  instruction's result returns via requester 1.
- stall  out  1  hold decode; combinational.
- sb_err  out  1  sticky protocol error.

Behaviour:
- Reset (synchronous, active-high):
  - rf_regwrite=0, rf_rd=0, rf_writedata=0.
  - Starvation counter=0, pending[31:0]=0, sb_err=0.
  - wb0_ready=wb1_ready=stall=0 while rst=1.
  - rst mid-transfer discards the in-flight write; nothing is written next cycle.
- Arbitration (combinational, same cycle):
  - Normal: if wb0_valid, grant 0; else if wb1_valid, grant 1.
  - Aged (counter==MAX_WAIT and wb1_valid): grant 1, even if wb0_valid.
  - At most one ready high per cycle; ready never high without its valid.
  - Transfer = valid && ready. Requesters hold rd/data stable until transfer.
- Write port timing:
  - Outputs are registered: a transfer in cycle N drives rf_regwrite/rf_rd/rf_writedata in cycle N+1.
  - Latency is 1 cycle.
  - rf_regwrite=0 in any cycle following no transfer.
  - Transfer with rd==0 is accepted but rf_regwrite=0 (write suppressed).
- Starvation counter:
  - Increments (saturating at MAX_WAIT) when wb1_valid && !wb1_ready.
  - Clears to 0 when requester 1 transfers or when wb1_valid=0.
  - Worst-case requester 1 wait: MAX_WAIT+1 cycles.
- Scoreboard (only with the optional feature):
  - stall = iss_valid && (pending[iss_rs] || pending[iss_rt] || (iss_we && pending[iss_rd])).
  - pending[0] is never set.
  - Issue accepted (iss_valid && !stall && iss_we && iss_long && iss_rd!=0): set pending[iss_rd] at posedge.
  - Requester 1 transfer: clear pending[wb1_rd] at posedge.
  - If requester 1 transfers to a register that is not pending, set sb_err; it stays set until rst.
  - Requester 0 never touches pending.
  - stall uses registered pending. A clear in the current cycle releases stall in the next cycle (conservative by one cycle).
  - Same-register set and clear in one cycle cannot occur: a WAW issue stalls.

Optional Feature:
- Macro: RF_ARB_SCOREBOARD_EN.
- Defined: scoreboard, stall and sb_err behave as above.
- Undefined:
  - No pending state is synthesized.
  - stall=0 and sb_err=0 always.
  - iss_* ports remain present and are ignored.
  - Arbitration and write port are unchanged.

Test Plan:
- Reset: assert rst 2 cycles with wb0_valid=1 -> rf_regwrite=0, wb0_ready=0, stall=0; first write appears the cycle after rst deasserts plus transfer.
- Single write: wb0 rd=5, data=0xDEADBEEF -> wb0_ready=1 same cycle; next cycle rf_regwrite=1, rf_rd=5, rf_writedata=0xDEADBEEF.
- Contention: wb0 and wb1 valid continuously, MAX_WAIT=4 -> wb0 granted 4 cycles, wb1 granted on the 5th, counter resets, pattern repeats.
- rd=0: wb1 rd=0, data=0x1234 -> wb1_ready=1; next cycle rf_regwrite=0.
- Scoreboard: issue long op rd=7 -> next cycle, issue rs=7 gives stall=1; wb1 rd=7 transfers; stall=0 one cycle later; sb_err stays 0.
- Error: wb1 transfer to rd=9 with pending[9]=0 -> sb_err=1 next cycle and sticky until rst; with macro undefined, sb_err=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: requester 0 has fixed priority, requester 1 ages in after MAX_WAIT denials.
// Define RF_ARB_SCOREBOARD_EN to add the long-latency pending scoreboard (stall / sb_err).
module rf_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb0_valid,
  output logic        wb0_ready,
  input  logic [4:0]  wb0_rd,
  input  logic [31:0] wb0_data,
  input  logic        wb1_valid,
  output logic        wb1_ready,
  input  logic [4:0]  wb1_rd,
  input  logic [31:0] wb1_data,
  output logic        rf_regwrite,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_writedata,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rs,
  input  logic [4:0]  iss_rt,
  input  logic [4:0]  iss_rd,
  input  logic        iss_we,
  input  logic        iss_long,
  output logic        stall,
  output logic        sb_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic             grant0;
  logic             grant1;
  logic             xfer;
  logic [4:0]       win_rd;
  logic [31:0]      win_data;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             rf_regwrite_reg;
  logic [4:0]       rf_rd_reg;
  logic [31:0]      rf_writedata_reg;

  // Grants are suppressed during reset so nothing is accepted that would be discarded.
  always_comb begin
    grant1   = !rst && wb1_valid && ((cnt_reg == MAX_CNT) || !wb0_valid);
    grant0   = !rst && wb0_valid && !grant1;
    xfer     = grant0 || grant1;
    win_rd   = grant1 ? wb1_rd   : wb0_rd;
    win_data = grant1 ? wb1_data : wb0_data;
  end

  assign wb0_ready = grant0;
  assign wb1_ready = grant1;

  always_comb begin
    cnt_next = cnt_reg;
    if (!wb1_valid || grant1)
      cnt_next = '0;
    else if (cnt_reg != MAX_CNT)
      cnt_next = cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_regwrite_reg  <= 1'b0;
      rf_rd_reg        <= 5'd0;
      rf_writedata_reg <= 32'd0;
      cnt_reg          <= '0;
    end else begin
      rf_regwrite_reg <= xfer && (win_rd != 5'd0);
      if (xfer) begin
        rf_rd_reg        <= win_rd;
        rf_writedata_reg <= win_data;
      end
      cnt_reg <= cnt_next;
    end
  end

  assign rf_regwrite  = rf_regwrite_reg;
  assign rf_rd        = rf_rd_reg;
  assign rf_writedata = rf_writedata_reg;

`ifdef RF_ARB_SCOREBOARD_EN
  logic [31:0] pending_reg;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic        sb_err_reg;
  logic        issue_ok;

  // stall looks only at registered pending, so a same-cycle clear releases it one cycle late.
  assign stall    = !rst && iss_valid &&
                    (pending_reg[iss_rs] || pending_reg[iss_rt] || (iss_we && pending_reg[iss_rd]));
  assign issue_ok = iss_valid && !stall && iss_we && iss_long && (iss_rd != 5'd0);

  for (genvar gi = 0; gi < 32; gi++) begin : g_pending
    assign set_vec[gi] = issue_ok && (iss_rd == 5'(gi));
    assign clr_vec[gi] = grant1 && (wb1_rd == 5'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= 32'd0;
      sb_err_reg  <= 1'b0;
    end else begin
      pending_reg <= ((pending_reg & ~clr_vec) | set_vec) & ~32'd1;
      if (grant1 && !pending_reg[wb1_rd])
        sb_err_reg <= 1'b1;
    end
  end

  assign sb_err = sb_err_reg;
`else
  logic unused_iss;
  assign unused_iss = ^{iss_valid, iss_rs, iss_rt, iss_rd, iss_we, iss_long};
  assign stall      = 1'b0;
  assign sb_err     = 1'b0;
`endif

endmodule
